// File: rtl/sqrt_controller_if.sv
// Control/handshake bundle between the sqrt controller, its requester and the square-root datapath.
interface sqrt_controller_if #(
    parameter int DATA_WITDH = 32
);
    logic                  start_i;
    logic [DATA_WITDH-1:0] operand_i;
    logic                  negative_i;
    logic                  ready_o;
    logic                  done_o;
    logic                  err_o;
    logic                  IE_o;
    logic                  WE_o;
    logic                  OE_o;
    logic [2:0]            ADDR_WR_o;
    logic [2:0]            ADDR_RDA_o;
    logic [2:0]            ADDR_RDB_o;
    logic [1:0]            ALU_Op_o;
    logic [DATA_WITDH-1:0] dp_data_o;

    // Controller side: consumes requests and the ALU flag, drives datapath controls.
    modport slave (
        input  start_i, operand_i, negative_i,
        output ready_o, done_o, err_o, IE_o, WE_o, OE_o,
               ADDR_WR_o, ADDR_RDA_o, ADDR_RDB_o, ALU_Op_o, dp_data_o
    );

    // Environment side: requester plus datapath.
    modport master (
        output start_i, operand_i, negative_i,
        input  ready_o, done_o, err_o, IE_o, WE_o, OE_o,
               ADDR_WR_o, ADDR_RDA_o, ADDR_RDB_o, ALU_Op_o, dp_data_o
    );
endinterface

// File: rtl/sqrt_controller.sv
// floor(sqrt(N)) sequencer driving a 4-register datapath by odd-number subtraction.
// Latency 4q+7 cycles to done (1 on rejected operand); start_i only honoured in IDLE, no queueing.
module sqrt_controller #(
    parameter int DATA_WITDH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    sqrt_controller_if.slave   bus
);
    localparam int MSB = DATA_WITDH - 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_N   = 4'd1;
    localparam logic [3:0] S_LOAD_ONE = 4'd2;
    localparam logic [3:0] S_CLR_Q    = 4'd3;
    localparam logic [3:0] S_SET_ODD  = 4'd4;
    localparam logic [3:0] S_SUB      = 4'd5;
    localparam logic [3:0] S_INC_Q    = 4'd6;
    localparam logic [3:0] S_ADD_ODD1 = 4'd7;
    localparam logic [3:0] S_ADD_ODD2 = 4'd8;
    localparam logic [3:0] S_OUT      = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;
    localparam logic [3:0] S_ERR      = 4'd11;

    // R0 remainder, R1 constant one, R2 quotient, R3 current odd number
    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;

    logic [3:0]            state_q, state_d;
    logic [DATA_WITDH-1:0] op_q, op_d;

    logic                  ready;
    logic                  done;
    logic                  err;
    logic                  ie;
    logic                  we;
    logic                  oe;
    logic [2:0]            addr_wr;
    logic [2:0]            addr_rda;
    logic [2:0]            addr_rdb;
    logic [1:0]            alu_op;
    logic [DATA_WITDH-1:0] dp_data;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    op_d    = bus.operand_i;
                    state_d = bus.operand_i[MSB] ? S_ERR : S_LOAD_N;
                end
            end
            S_LOAD_N:   state_d = S_LOAD_ONE;
            S_LOAD_ONE: state_d = S_CLR_Q;
            S_CLR_Q:    state_d = S_SET_ODD;
            S_SET_ODD:  state_d = S_SUB;
            // A negative trial remainder means the last odd number did not fit: q is final.
            S_SUB:      state_d = bus.negative_i ? S_OUT : S_INC_Q;
            S_INC_Q:    state_d = S_ADD_ODD1;
            S_ADD_ODD1: state_d = S_ADD_ODD2;
            S_ADD_ODD2: state_d = S_SUB;
            S_OUT:      state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            S_ERR:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        ie       = 1'b0;
        we       = 1'b0;
        oe       = 1'b0;
        addr_wr  = R0;
        addr_rda = R0;
        addr_rdb = R0;
        alu_op   = OP_ADD;
        dp_data  = '0;
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_LOAD_N: begin
                ie      = 1'b1;
                we      = 1'b1;
                addr_wr = R0;
                dp_data = op_q;
            end
            S_LOAD_ONE: begin
                ie      = 1'b1;
                we      = 1'b1;
                addr_wr = R1;
                dp_data = DATA_WITDH'(1);
            end
            S_CLR_Q: begin
                addr_rda = R1;
                addr_rdb = R1;
                alu_op   = OP_SUB;
                we       = 1'b1;
                addr_wr  = R2;
            end
            S_SET_ODD: begin
                addr_rda = R1;
                alu_op   = OP_PASS;
                we       = 1'b1;
                addr_wr  = R3;
            end
            S_SUB: begin
                addr_rda = R0;
                addr_rdb = R3;
                alu_op   = OP_SUB;
                addr_wr  = R0;
                we       = ~bus.negative_i;
            end
            S_INC_Q: begin
                addr_rda = R2;
                addr_rdb = R1;
                alu_op   = OP_ADD;
                we       = 1'b1;
                addr_wr  = R2;
            end
            S_ADD_ODD1, S_ADD_ODD2: begin
                addr_rda = R3;
                addr_rdb = R1;
                alu_op   = OP_ADD;
                we       = 1'b1;
                addr_wr  = R3;
            end
            S_OUT: begin
                addr_rda = R2;
                alu_op   = OP_PASS;
                oe       = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign bus.ready_o    = ready;
    assign bus.done_o     = done;
    assign bus.err_o      = err;
    assign bus.IE_o       = ie;
    assign bus.WE_o       = we;
    assign bus.OE_o       = oe;
    assign bus.ADDR_WR_o  = addr_wr;
    assign bus.ADDR_RDA_o = addr_rda;
    assign bus.ADDR_RDB_o = addr_rdb;
    assign bus.ALU_Op_o   = alu_op;
    assign bus.dp_data_o  = dp_data;
endmodule

// File: tb/tb_sqrt_controller.sv
// Bench for sqrt_controller: behavioural datapath around the controller, expected results from integer sqrt.
module tb_sqrt_controller;
    logic clk = 1'b0;
    logic rst_n;

    sqrt_controller_if #(.DATA_WITDH(32)) bus ();

    sqrt_controller #(.DATA_WITDH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Datapath: 8-entry register file, ALU, output register.
    logic [31:0] rf [8];
    logic [31:0] dp_out = 32'd0;
    logic [31:0] alu_a, alu_b, alu_y;

    always_comb begin
        alu_a = rf[bus.ADDR_RDA_o];
        alu_b = rf[bus.ADDR_RDB_o];
        case (bus.ALU_Op_o)
            2'b00:   alu_y = alu_a + alu_b;
            2'b01:   alu_y = alu_a - alu_b;
            2'b10:   alu_y = alu_a;
            default: alu_y = 32'd0;
        endcase
        bus.negative_i = alu_y[31];
    end

    always @(posedge clk) begin
        if (bus.WE_o) rf[bus.ADDR_WR_o] <= bus.IE_o ? bus.dp_data_o : alu_y;
        if (bus.OE_o) dp_out <= alu_y;
    end

    int checks = 0;
    int failures = 0;
    int cyc, done_cnt, oe_cnt, we_cnt, dbl_done, done_at, first_done_at;
    logic prev_done, err_at_done, we_c5;
    logic [31:0] data_at_done, first_data, dpd_c1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int isqrt(input logic [31:0] n);
        longint q = 0;
        while ((q + 1) * (q + 1) <= longint'(n)) q++;
        return int'(q);
    endfunction

    task automatic clear_counts();
        cyc = 0; done_cnt = 0; oe_cnt = 0; we_cnt = 0; dbl_done = 0;
        done_at = -1; first_done_at = -1; prev_done = 1'b0;
        err_at_done = 1'b0; data_at_done = 32'hDEADBEEF; first_data = 32'hDEADBEEF;
        we_c5 = 1'b0; dpd_c1 = 32'd0;
    endtask

    // Advance to the middle of the next cycle and record what the controller shows there.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc == 1) dpd_c1 = bus.dp_data_o;
        if (cyc == 5) we_c5 = bus.WE_o;
        if (bus.done_o) begin
            done_cnt++;
            if (prev_done) dbl_done++;
            done_at = cyc;
            err_at_done = bus.err_o;
            data_at_done = dp_out;
            if (done_cnt == 1) begin
                first_done_at = cyc;
                first_data = dp_out;
            end
        end
        prev_done = bus.done_o;
        if (bus.OE_o) oe_cnt++;
        if (bus.WE_o) we_cnt++;
    endtask

    // One operand from an idle controller; optional random start noise while busy.
    task automatic run_op(input logic [31:0] n, input string tag, input bit noise);
        bit exp_err;
        int q, exp_done;
        logic [31:0] prev_data;
        exp_err   = n[31];
        q         = exp_err ? 0 : isqrt(n);
        exp_done  = exp_err ? 1 : 4 * q + 7;
        prev_data = dp_out;
        bus.start_i   = 1'b1;
        bus.operand_i = n;
        @(posedge clk);
        clear_counts();
        while (done_cnt == 0 && cyc < exp_done + 10) begin
            step();
            if (noise && !bus.done_o) begin
                bus.start_i   = 1'($urandom_range(0, 1));
                bus.operand_i = $urandom;
            end else begin
                bus.start_i = 1'b0;
            end
        end
        bus.start_i = 1'b0;
        check({tag, "_done_cycle"}, done_at, exp_done);
        check({tag, "_err"}, err_at_done, exp_err);
        check({tag, "_data"}, data_at_done, exp_err ? prev_data : q);
        check({tag, "_oe_count"}, oe_cnt, exp_err ? 0 : 1);
        if (exp_err) check({tag, "_we_count"}, we_cnt, 0);
        else         check({tag, "_load_word"}, dpd_c1, n);
        step();
        check({tag, "_ready_after"}, bus.ready_o, 1);
        check({tag, "_done_single"}, bus.done_o, 0);
    endtask

    int acc2;
    logic [31:0] rn;
    int k;

    initial begin
        rst_n = 1'b0;
        bus.start_i = 1'b1;
        bus.operand_i = 32'd15;
        clear_counts();

        // Reset held with a pending request.
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready_o, 1);
        check("rst_ctrl", 32'({bus.IE_o, bus.WE_o, bus.OE_o, bus.done_o, bus.err_o,
                               bus.ALU_Op_o, bus.ADDR_WR_o, bus.ADDR_RDA_o, bus.ADDR_RDB_o}), 0);
        check("rst_dpdata", bus.dp_data_o, 0);
        rst_n = 1'b1;
        check("rel_we", bus.WE_o, 0);
        run_op(32'd15, "n15_after_rst", 1'b0);

        run_op(32'd0, "n0", 1'b0);
        check("n0_sub_we", we_c5, 0);
        run_op(32'd16, "n16", 1'b0);
        run_op(32'd1, "n1", 1'b0);
        check("n1_sub_we", we_c5, 1);
        run_op(32'h8000_0000, "neg_min", 1'b0);

        // Reset in the middle of N=100.
        bus.start_i = 1'b1;
        bus.operand_i = 32'd100;
        @(posedge clk);
        clear_counts();
        while (cyc < 12) begin
            step();
            bus.start_i = 1'b0;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_ready", bus.ready_o, 1);
        repeat (4) step();
        check("midrst_oe", oe_cnt, 0);
        check("midrst_done", done_cnt, 0);
        run_op(32'd81, "n81_after_midrst", 1'b1);

        // Back-to-back with start held.
        acc2 = -1;
        bus.start_i = 1'b1;
        bus.operand_i = 32'd4;
        @(posedge clk);
        clear_counts();
        while (cyc < 45) begin
            step();
            if (acc2 < 0 && bus.ready_o) begin
                acc2 = cyc;
                bus.operand_i = 32'd9;
            end else if (acc2 >= 0 && cyc == acc2 + 1) begin
                bus.start_i = 1'b0;
            end
        end
        bus.start_i = 1'b0;
        check("b2b_accept2", acc2, 16);
        check("b2b_done_count", done_cnt, 2);
        check("b2b_done1_cycle", first_done_at, 15);
        check("b2b_data1", first_data, 2);
        check("b2b_done2_cycle", done_at, 35);
        check("b2b_data2", data_at_done, 3);
        check("b2b_no_double", dbl_done, 0);

        // Randomized operands, with start noise while busy.
        for (int i = 0; i < 6; i++) begin
            rn = 32'($urandom_range(0, 200000));
            run_op(rn, $sformatf("rand%0d", i), 1'b1);
        end
        k = $urandom_range(2, 300);
        run_op(32'(k * k), "rand_square", 1'b1);
        run_op(32'(k * k - 1), "rand_square_m1", 1'b1);
        rn = $urandom;
        rn[31] = 1'b1;
        run_op(rn, "rand_neg", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sqrt_controller.md
# sqrt_controller

Control FSM sitting directly upstream of the square-root datapath. It drives the datapath's control bundle (IE, WE, OE, write/read register addresses, ALU opcode) and the data word muxed into the register file. It computes floor(sqrt(N)) for a 32-bit operand by odd-number subtraction. It accepts one operand per start/ready handshake and signals completion with a one-cycle done pulse, while the datapath's output register holds the result.

## Interface
- DATA_WITDH, 32, operand/datapath word width (bit DATA_WITDH-1 is the sign bit)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  request; sampled only while ready_o=1
- operand_i  in  DATA_WITDH  N; captured on the accepting edge
- negative_i  in  1  datapath ALU negative flag (combinational, same cycle)
- ready_o  out  1  high in IDLE only
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; 1 = operand rejected
- IE_o  out  1  1 selects dp_data_o into register file, 0 selects ALU result
- WE_o  out  1  register-file write enable
- OE_o  out  1  datapath output-register load
- ADDR_WR_o, ADDR_RDA_o, ADDR_RDB_o  out  3 each  register addresses
- ALU_Op_o  out  2  00 ADD (A+B), 01 SUB (A-B), 10 PASS (A), 11 never emitted
- dp_data_o  out  DATA_WITDH  word presented to the datapath data input

## Operation
- Register map: R0 = remainder, R1 = constant 1, R2 = quotient q, R3 = current odd number.
- Default in every state unless listed: IE=WE=OE=0, all addresses 0, ALU_Op=00, dp_data_o=0.
- IDLE: ready_o=1. If start_i=1, capture operand_i into op_q. If operand_i[MSB]=1, go to ERR; otherwise go to LOAD_N.
- LOAD_N: IE=1, WE=1, WR=R0, dp_data_o=op_q.
- LOAD_ONE: IE=1, WE=1, WR=R1, dp_data_o=1.
- CLR_Q: RDA=R1, RDB=R1, SUB, WE=1, WR=R2 (R2 := 0).
- SET_ODD: RDA=R1, PASS, WE=1, WR=R3 (R3 := 1).
- SUB: RDA=R0, RDB=R3, SUB, WR=R0, WE=~negative_i (Mealy).
  - negative_i=0: go to INC_Q.
  - negative_i=1: no write; go to OUT.
- INC_Q: RDA=R2, RDB=R1, ADD, WE=1, WR=R2.
- ADD_ODD1, then ADD_ODD2: each RDA=R3, RDB=R1, ADD, WE=1, WR=R3. The pair adds 2. Then go to SUB.
- OUT: RDA=R2, PASS, OE=1 (datapath data_o := q).
- DONE: done_o=1, err_o=0. Go to IDLE.
- ERR: done_o=1, err_o=1. No WE or OE is asserted for this operand; datapath data_o keeps its prior value. Go to IDLE.
- start_i is ignored outside IDLE; no queueing.
- Result is exact floor(sqrt(N)) for 0 <= N <= 2^31-1. The largest q is 46340. The largest odd number is 92681, so no overflow is possible.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, op_q=0, ready_o=1, and every other output 0. This holds even mid-computation. Register-file contents are not touched by reset and are reloaded by the next operand.
- Cycle 1 is the first cycle after the accepting edge. The state sequence is LOAD_N, LOAD_ONE, CLR_Q, SET_ODD, then q repetitions of (SUB, INC_Q, ADD_ODD1, ADD_ODD2), then the failing SUB, OUT, DONE.
- done_o is high in cycle 4q+7. Datapath data_o holds q from the start of that same cycle.
- ready_o returns high in cycle 4q+8. A start_i asserted in that cycle is accepted, giving back-to-back throughput of 4q+8 cycles per operand.
- Error path: done_o=1 and err_o=1 in cycle 1; ready_o high in cycle 2.
- negative_i is consumed combinationally only in SUB. It is ignored in every other state.
- done_o and err_o are never high for more than one consecutive cycle.

## Test plan
- Reset with start_i=1 held: after release, ready_o=1, all control outputs 0, and no WE for 1 cycle. Start is then accepted on the first edge with rst_n=1.
- N=0: done_o in cycle 7, err_o=0, data_o=0. WE_o is low in the SUB cycle (cycle 5).
- N=16: done_o in cycle 23, data_o=4. N=15: done_o in cycle 19, data_o=3. N=1: done_o in cycle 11, data_o=1.
- N=0x80000000: done_o and err_o in cycle 1, no WE_o or OE_o pulse, data_o unchanged from the previous result.
- N=100 with rst_n pulsed low in cycle 12: the FSM returns to IDLE and no OE_o occurs. A follow-up N=81 gives data_o=9 at cycle 43.
- Back-to-back: N=4 then N=9, with start_i held high. The second operand is accepted in cycle 16 (4q+8 for q=2). start_i pulses during busy cycles are ignored, and exactly two done_o pulses are produced.
